// File: rtl/poly_mux_arbiter_pkg.sv
// Shared constants and state encoding for the polynomial multiplexer arbiter.
package poly_mux_arbiter_pkg;

   localparam int KYBER_N   = 256;
   localparam int POLY_W    = KYBER_N * 16;
   localparam int NUM_SRC   = 5;
   localparam int MAX_BEATS = 4;
   localparam int SEL_W     = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/poly_mux_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr+1,
// wrapping around, so the source at ptr itself is considered last.
module rr_picker #(
   parameter int NUM_SRC = 5,
   parameter int SEL_W   = 3
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic [SEL_W-1:0]   winner,
   output logic               any_valid
);

   always_comb begin
      int               idx;
      logic [SEL_W-1:0] cand;
      // NOTE: every output gets a default before the loop, otherwise a
      // path with no requester would hold its old value and infer a latch.
      winner    = '0;
      any_valid = 1'b0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         cand = SEL_W'(idx);
         if (!any_valid && req[cand]) begin
            winner    = cand;
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/poly_mux_arbiter.sv
// Round-robin owner arbitration for the shared polynomial multiplexer; drives
// the mux selector only, never the polynomial data.
module poly_mux_arbiter #(
   parameter int NUM_SRC   = 5,
   parameter int MAX_BEATS = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [NUM_SRC-1:0]                    req,
   input  logic                                  out_ready,
   output logic [poly_mux_arbiter_pkg::SEL_W-1:0] sel,
   output logic [NUM_SRC-1:0]                    grant,
   output logic                                  out_valid,
   output logic                                  busy
);

   import poly_mux_arbiter_pkg::*;

   localparam int BEAT_W = $clog2(MAX_BEATS + 1);

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [NUM_SRC-1:0] grant_d;
   logic [BEAT_W-1:0]  beat_q, beat_d, beat_inc;
   logic [SEL_W-1:0]   winner;
   logic               any_valid;
   logic               handshake;

   rr_picker #(
      .NUM_SRC (NUM_SRC),
      .SEL_W   (SEL_W)
   ) u_picker (
      .req       (req),
      .ptr       (ptr_q),
      .winner    (winner),
      .any_valid (any_valid)
   );

   assign busy      = (state_q == GRANT);
   assign out_valid = busy & req[sel];
   assign handshake = out_valid & out_ready;
   assign beat_inc  = beat_q + BEAT_W'(1);

   always_comb begin
      state_d = state_q;
      sel_d   = sel;
      ptr_d   = ptr_q;
      grant_d = grant;
      beat_d  = beat_q;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               state_d         = GRANT;
               sel_d           = winner;
               ptr_d           = winner;
               grant_d         = '0;
               grant_d[winner] = 1'b1;
               beat_d          = '0;
            end
         end
         GRANT: begin
            // Owner withdrawal or the beat limit both release; sel is left
            // pointing at the old owner so the mux output stays stable.
            if (!req[sel] || (handshake && beat_inc == BEAT_W'(MAX_BEATS))) begin
               state_d = IDLE;
               grant_d = '0;
               beat_d  = '0;
            end else if (handshake) begin
               beat_d = beat_inc;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            beat_d  = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel     <= '0;
         ptr_q   <= SEL_W'(NUM_SRC - 1);
         grant   <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         sel     <= sel_d;
         ptr_q   <= ptr_d;
         grant   <= grant_d;
         beat_q  <= beat_d;
      end
   end

endmodule

// File: tb/tb_poly_mux_arbiter.sv
// Scoreboard bench for poly_mux_arbiter: directed scenarios queue expected
// handshake owners, a negedge monitor pops and checks them plus invariants.
module tb_poly_mux_arbiter;

   localparam int NSRC         = 5;
   localparam int BEATS        = 4;
   localparam int STARVE_LIMIT = 4 * (BEATS + 1);

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] req;
   logic       out_ready;
   logic [2:0] sel;
   logic [4:0] grant;
   logic       out_valid;
   logic       busy;

   int tests = 0;
   int fails = 0;
   int exp_q[$];
   int wait_cnt[NSRC];
   bit sb_en     = 1'b0;
   bit inv_en    = 1'b0;
   bit starve_en = 1'b0;

   poly_mux_arbiter #(
      .NUM_SRC   (NSRC),
      .MAX_BEATS (BEATS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .out_ready (out_ready),
      .sel       (sel),
      .grant     (grant),
      .out_valid (out_valid),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_owner(input int owner, input int n);
      repeat (n) exp_q.push_back(owner);
   endtask

   task automatic expect_grant(input string tag, input int owner);
      check({tag, "_busy"},  32'(busy),  32'd1);
      check({tag, "_sel"},   32'(sel),   32'(owner));
      check({tag, "_grant"}, 32'(grant), 32'(1 << owner));
   endtask

   task automatic expect_idle(input string tag, input int sel_exp);
      check({tag, "_busy"},  32'(busy),      32'd0);
      check({tag, "_grant"}, 32'(grant),     32'd0);
      check({tag, "_sel"},   32'(sel),       32'(sel_exp));
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
   endtask

   // Monitor: handshakes against the queue, invariants every cycle.
   always @(negedge clk) begin
      int owner;
      int worst;
      if (sb_en && !rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL hs_extra: got handshake from sel=%0d, expected none (t=%0t)", sel, $time);
         end else begin
            owner = exp_q.pop_front();
            check("hs_sel",   32'(sel),   32'(owner));
            check("hs_grant", 32'(grant), 32'(1 << owner));
         end
      end
      if (inv_en) begin
         check("inv_onehot0", 32'($onehot0(grant)), 32'd1);
         check("inv_sel_range", 32'(sel < 3'(NSRC)), 32'd1);
         check("inv_valid_rule", 32'(out_valid), 32'(busy && req[sel]));
         worst = 0;
         for (int i = 0; i < NSRC; i++) begin
            if (req[i] && !grant[i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            if (wait_cnt[i] > worst) worst = wait_cnt[i];
         end
         // The cycle in which a request is raised is counted before the
         // arbiter has sampled it, hence the extra cycle of allowance.
         if (starve_en) check("inv_starvation", 32'(worst <= STARVE_LIMIT + 1), 32'd1);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NSRC; i++) wait_cnt[i] = 0;
      rst       = 1'b1;
      req       = '0;
      out_ready = 1'b0;
      sb_en     = 1'b1;
      tick();
      tick();
      expect_idle("reset", 0);
      rst    = 1'b0;
      inv_en = 1'b1;

      // Single requester: 4 beats, one idle bubble, regrant of itself.
      req       = 5'b00001;
      out_ready = 1'b1;
      push_owner(0, 8);
      tick();
      expect_grant("s1_grant", 0);
      repeat (4) tick();
      expect_idle("s1_release", 0);
      tick();
      expect_grant("s1_regrant", 0);
      repeat (4) tick();
      expect_idle("s1_end", 0);
      req = '0;

      // All requesting from reset: owners 0,1,2,3,4,0.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 5'b11111;
      for (int k = 0; k < 6; k++) push_owner(k % NSRC, 4);
      for (int k = 0; k < 6; k++) begin
         tick();
         expect_grant($sformatf("s2_grant%0d", k), k % NSRC);
         repeat (4) tick();
         expect_idle($sformatf("s2_release%0d", k), k % NSRC);
      end
      req = '0;

      // Owner 2 stalled for 3 cycles, then 4 beats.
      req       = 5'b00100;
      out_ready = 1'b0;
      tick();
      expect_grant("s3_grant", 2);
      repeat (3) begin
         tick();
         expect_grant("s3_stall", 2);
      end
      out_ready = 1'b1;
      push_owner(2, 4);
      repeat (3) tick();
      expect_grant("s3_beat3", 2);
      tick();
      expect_idle("s3_release", 2);
      req = '0;

      // Owner 3 drops after 2 beats; next winner wraps to source 0.
      req = 5'b01001;
      push_owner(3, 2);
      push_owner(0, 4);
      tick();
      expect_grant("s4_grant", 3);
      repeat (2) tick();
      req = 5'b00001;
      tick();
      expect_idle("s4_drop", 3);
      tick();
      expect_grant("s4_next", 0);
      repeat (4) tick();
      expect_idle("s4_end", 0);
      req = '0;

      // Reset mid-grant of owner 4; source 0 has priority afterwards.
      req = 5'b10000;
      push_owner(4, 1);
      tick();
      expect_grant("s5_grant", 4);
      tick();
      rst = 1'b1;
      req = 5'b10001;
      tick();
      expect_idle("s5_reset", 0);
      rst = 1'b0;
      push_owner(0, 1);
      tick();
      expect_grant("s5_first", 0);
      tick();
      req = '0;
      tick();
      expect_idle("s5_end", 0);
      check("sb_drain", 32'(exp_q.size()), 32'd0);

      // Random request traffic: invariants and starvation bound.
      sb_en     = 1'b0;
      starve_en = 1'b1;
      out_ready = 1'b1;
      repeat (4000) begin
         for (int i = 0; i < NSRC; i++)
            if ($urandom_range(5) == 0) req[i] = ~req[i];
         tick();
      end
      starve_en = 1'b0;
      repeat (4000) begin
         for (int i = 0; i < NSRC; i++)
            if ($urandom_range(5) == 0) req[i] = ~req[i];
         out_ready = 1'($urandom_range(1));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
